nitta_to_spi_splitter: RTL and testbench

NITTA_TO_SPI_SPLITTER -- requirements
Module: nitta_to_spi_splitter

---
 rtl/nitta_to_spi_splitter.sv | 131 +++++++++++++
 tb/tb_nitta_to_spi_splitter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/nitta_to_spi_splitter.sv
// Splits each DATA_WIDTH NITTA word into SPI_DATA_WIDTH subframes, MSB first,
// advancing one subframe per rising edge of spi_ready; one extra word may be queued.
module nitta_to_spi_splitter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ATTR_WIDTH     = 4,
  parameter int SPI_DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      nitta_ready,
  input  logic [DATA_WIDTH-1:0]     from_nitta,
  input  logic                      spi_ready,
  output logic                      splitter_ready,
  output logic [SPI_DATA_WIDTH-1:0] to_spi,
  output logic                      busy,
  output logic                      overflow
);

  localparam int SUBFRAME_NUMBER = DATA_WIDTH / SPI_DATA_WIDTH;
  localparam int CNT_W           = $clog2(SUBFRAME_NUMBER) + 1;

  if (ATTR_WIDTH < 1 || DATA_WIDTH % SPI_DATA_WIDTH != 0 || SUBFRAME_NUMBER < 2) begin : g_bad_params
    $error("nitta_to_spi_splitter: illegal parameter combination");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t                    state, state_d;
  logic [DATA_WIDTH-1:0]     shift_reg, shift_d;
  logic [CNT_W-1:0]          remaining, remaining_d;
  logic [DATA_WIDTH-1:0]     pending, pending_d;
  logic                      pending_valid, pending_valid_d;
  logic                      spi_ready_q;
  logic [SPI_DATA_WIDTH-1:0] to_spi_d;
  logic                      splitter_ready_d, overflow_d, busy_d;
  logic                      spi_edge, last_edge, direct_load, load;
  logic [DATA_WIDTH-1:0]     load_word;

  assign spi_edge  = spi_ready & ~spi_ready_q;
  assign last_edge = (state == SEND) && spi_edge && (remaining == '0);

  always_comb begin
    state_d          = state;
    shift_d          = shift_reg;
    remaining_d      = remaining;
    pending_d        = pending;
    pending_valid_d  = pending_valid;
    to_spi_d         = to_spi;
    splitter_ready_d = 1'b0;
    overflow_d       = 1'b0;
    load             = 1'b0;
    load_word        = '0;
    direct_load      = 1'b0;

    case (state)
      IDLE: begin
        if (nitta_ready) begin
          load      = 1'b1;
          load_word = from_nitta;
        end
      end
      SEND: begin
        if (spi_edge && remaining != '0) begin
          shift_d          = shift_reg << SPI_DATA_WIDTH;
          to_spi_d         = shift_reg[DATA_WIDTH-1-SPI_DATA_WIDTH -: SPI_DATA_WIDTH];
          remaining_d      = remaining - CNT_W'(1);
          splitter_ready_d = 1'b1;
        end else if (last_edge) begin
          if (pending_valid) begin
            load            = 1'b1;
            load_word       = pending;
            pending_valid_d = 1'b0;
          end else if (nitta_ready) begin
            load        = 1'b1;
            load_word   = from_nitta;
            direct_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        // A pending slot being drained this cycle is free for the incoming word.
        if (nitta_ready && !direct_load) begin
          if (!pending_valid || last_edge) begin
            pending_d       = from_nitta;
            pending_valid_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d          = load_word;
      to_spi_d         = load_word[DATA_WIDTH-1 -: SPI_DATA_WIDTH];
      remaining_d      = CNT_W'(SUBFRAME_NUMBER - 1);
      splitter_ready_d = 1'b1;
      state_d          = SEND;
    end

    busy_d = (state_d == SEND) | pending_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      shift_reg      <= '0;
      remaining      <= '0;
      pending        <= '0;
      pending_valid  <= 1'b0;
      spi_ready_q    <= 1'b1;
      to_spi         <= '0;
      splitter_ready <= 1'b0;
      overflow       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_d;
      shift_reg      <= shift_d;
      remaining      <= remaining_d;
      pending        <= pending_d;
      pending_valid  <= pending_valid_d;
      spi_ready_q    <= spi_ready;
      to_spi         <= to_spi_d;
      splitter_ready <= splitter_ready_d;
      overflow       <= overflow_d;
      busy           <= busy_d;
    end
  end

endmodule

// File: tb/tb_nitta_to_spi_splitter.sv
// Directed bench for nitta_to_spi_splitter: a word/queue level reference model is
// compared every cycle, and literal subframe sequences pin each scenario.
module tb_nitta_to_spi_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        nitta_ready;
  logic [31:0] from_nitta;
  logic        spi_ready;
  logic        splitter_ready;
  logic [7:0]  to_spi;
  logic        busy;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  nitta_to_spi_splitter #(
    .DATA_WIDTH    (32),
    .ATTR_WIDTH    (4),
    .SPI_DATA_WIDTH(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .nitta_ready   (nitta_ready),
    .from_nitta    (from_nitta),
    .spi_ready     (spi_ready),
    .splitter_ready(splitter_ready),
    .to_spi        (to_spi),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an active word with a subframe index, plus a queue holding at most one waiting word.
  bit          m_started = 0;
  bit          m_active;
  logic [31:0] m_word;
  int          m_k;
  logic [31:0] m_pq[$];
  logic        m_prev;
  logic        e_sr, e_ov, e_busy;
  logic [7:0]  e_to;

  function automatic logic [7:0] subframe(input logic [31:0] w, input int k);
    return 8'((w >> (32 - 8 * (k + 1))) & 32'hFF);
  endfunction

  task automatic m_start(input logic [31:0] w);
    m_active = 1;
    m_word   = w;
    m_k      = 0;
    e_to     = subframe(w, 0);
    e_sr     = 1;
  endtask

  always @(posedge clk) begin
    bit e, took_new;
    m_started = 1;
    if (rst) begin
      m_active = 0; m_k = 0; m_pq.delete(); m_prev = 1;
      e_sr = 0; e_ov = 0; e_busy = 0; e_to = 8'h00;
    end else begin
      e        = spi_ready && !m_prev;
      m_prev   = spi_ready;
      e_sr     = 0;
      e_ov     = 0;
      took_new = 0;
      if (!m_active) begin
        if (nitta_ready) m_start(from_nitta);
      end else begin
        if (e && m_k < 3) begin
          m_k++;
          e_to = subframe(m_word, m_k);
          e_sr = 1;
        end else if (e) begin
          if (m_pq.size() > 0) m_start(m_pq.pop_front());
          else if (nitta_ready) begin m_start(from_nitta); took_new = 1; end
          else m_active = 0;
        end
        if (nitta_ready && !took_new) begin
          if (m_pq.size() == 0) m_pq.push_back(from_nitta);
          else e_ov = 1;
        end
      end
      e_busy = m_active || (m_pq.size() > 0);
    end
  end

  logic [7:0] got[$];
  logic [7:0] expq[$];
  int         ov_cnt = 0;

  always @(negedge clk) begin
    if (m_started) begin
      chk("model_splitter_ready", 32'(splitter_ready), 32'(e_sr));
      chk("model_to_spi",         32'(to_spi),         32'(e_to));
      chk("model_busy",           32'(busy),           32'(e_busy));
      chk("model_overflow",       32'(overflow),       32'(e_ov));
      if (splitter_ready === 1'b1) got.push_back(to_spi);
      if (overflow === 1'b1) ov_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    nitta_ready = 1'b1;
    from_nitta  = w;
    tick();
    nitta_ready = 1'b0;
  endtask

  task automatic spi_pulse();
    spi_ready = 1'b1;
    tick();
    spi_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_got(input string name);
    chk({name, "_count"}, 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      chk(name, 32'(got[i]), 32'(expq[i]));
    got.delete();
  endtask

  initial begin
    int ov_before;
    rst = 1'b1; nitta_ready = 1'b0; from_nitta = '0; spi_ready = 1'b0;
    repeat (3) tick();
    chk("reset_to_spi", 32'(to_spi), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();

    // Basic send
    got.delete();
    send_word(32'hDEADBEEF);
    repeat (4) spi_pulse();
    tick();
    expq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    check_got("basic_seq");
    chk("basic_busy_low", 32'(busy), 32'h0);

    // Back-to-back with the second word arriving during byte 22
    send_word(32'h11223344);
    spi_pulse();
    send_word(32'hAABBCCDD);
    spi_pulse();
    spi_pulse();
    spi_ready = 1'b1;
    tick();
    chk("b2b_aa_ready", 32'(splitter_ready), 32'h1);
    chk("b2b_aa_data", 32'(to_spi), 32'hAA);
    spi_ready = 1'b0;
    tick(); tick();
    repeat (4) spi_pulse();
    tick();
    expq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    check_got("b2b_seq");

    // Overflow: third word dropped
    ov_before = ov_cnt;
    send_word(32'h01020304);
    send_word(32'h05060708);
    send_word(32'h99999999);
    repeat (8) spi_pulse();
    tick();
    chk("ovf_pulses", 32'(ov_cnt - ov_before), 32'h1);
    expq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    check_got("ovf_seq");
    chk("ovf_busy_low", 32'(busy), 32'h0);

    // New word on the same cycle as the last-subframe edge
    ov_before = ov_cnt;
    send_word(32'hA1B2C3D4);
    repeat (3) spi_pulse();
    spi_ready = 1'b1; nitta_ready = 1'b1; from_nitta = 32'h5A6B7C8D;
    tick();
    spi_ready = 1'b0; nitta_ready = 1'b0;
    chk("simul_ready", 32'(splitter_ready), 32'h1);
    chk("simul_data", 32'(to_spi), 32'h5A);
    tick(); tick();
    repeat (4) spi_pulse();
    tick();
    chk("simul_no_ovf", 32'(ov_cnt - ov_before), 32'h0);
    expq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h5A, 8'h6B, 8'h7C, 8'h8D};
    check_got("simul_seq");

    // Reset mid-word with spi_ready held high
    send_word(32'hDEADBEEF);
    spi_pulse();
    spi_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    chk("rst_mid_to_spi", 32'(to_spi), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_ready", 32'(splitter_ready), 32'h0);
    rst = 1'b0;
    got.delete();
    tick(); tick();
    send_word(32'h12345678);
    repeat (4) tick();
    expq = '{8'h12};
    check_got("rst_hold_seq");
    chk("rst_hold_to_spi", 32'(to_spi), 32'h12);
    spi_ready = 1'b0;
    tick();
    spi_ready = 1'b1;
    tick();
    chk("rst_toggle_data", 32'(to_spi), 32'h34);
    chk("rst_toggle_ready", 32'(splitter_ready), 32'h1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
